// File: rtl/ex_hazard_fwd_ctrl_pkg.sv
// ex_hazard_fwd_ctrl_pkg: shared forward encodings, FSM states and scoreboard slot layout.
package ex_hazard_fwd_ctrl_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  typedef enum logic [1:0] {ST_RUN, ST_LU_STALL, ST_FLUSH} state_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wb;
    logic       load;
  } slot_t;
  // x0 is hardwired, so a write to it never produces a value worth forwarding
  function automatic logic produces(slot_t s, logic [4:0] r);
    return s.valid & s.wb & (s.rd != 5'd0) & (s.rd == r);
  endfunction
endpackage

// File: rtl/ex_hazard_fwd_ctrl_if.sv
// ex_hazard_fwd_ctrl_if: ID-stage fields in, pipeline control and forward selects out.
interface ex_hazard_fwd_ctrl_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic             id_wb_reg_file;
  logic             id_memtoreg;
  logic             branch_taken_ex;
  logic             mem_stall;
  logic             stall_if_id;
  logic             bubble_id_ex;
  logic             flush_if_id;
  logic [1:0]       operand_a_forward_cntl;
  logic [1:0]       operand_b_forward_cntl;
  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_wb_reg_file,
           id_memtoreg, branch_taken_ex, mem_stall,
    input  stall_if_id, bubble_id_ex, flush_if_id, operand_a_forward_cntl,
           operand_b_forward_cntl, lu_stall_cnt, flush_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_wb_reg_file,
           id_memtoreg, branch_taken_ex, mem_stall,
    output stall_if_id, bubble_id_ex, flush_if_id, operand_a_forward_cntl,
           operand_b_forward_cntl, lu_stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ex_hazard_fwd_ctrl_hz_fwd_sel.sv
// hz_fwd_sel: per-operand forward select and load-use detect against the EX/MEM scoreboard.
module hz_fwd_sel
  import ex_hazard_fwd_ctrl_pkg::*;
(
  input  logic       i_used,
  input  logic [4:0] i_rs,
  input  slot_t      i_ex,
  input  slot_t      i_mem,
  output logic [1:0] o_fwd,
  output logic       o_lu
);
  logic w_ex, w_mem;
  always_comb begin
    w_ex  = produces(i_ex, i_rs);
    w_mem = produces(i_mem, i_rs);
    o_fwd = !i_used ? FWD_RF : (w_ex && !i_ex.load) ? FWD_MEM : w_mem ? FWD_WB : FWD_RF;
    o_lu  = i_used & w_ex & i_ex.load;
  end
endmodule

// File: rtl/ex_hazard_fwd_ctrl.sv
// ex_hazard_fwd_ctrl: EX-stage forwarding selects plus load-use stall, branch flush and
// memory-stall freeze control.
module ex_hazard_fwd_ctrl
  import ex_hazard_fwd_ctrl_pkg::*;
#(
  parameter int FLUSH_EXTRA = 0,
  parameter int CNT_W       = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  ex_hazard_fwd_ctrl_if.slave  bus
);
  localparam logic [2:0] LP_FE = 3'(FLUSH_EXTRA);
  state_t           r_state;
  logic [2:0]       r_fcnt;
  slot_t            r_ex, r_mem;
  logic [1:0]       r_fa, r_fb;
  logic [CNT_W-1:0] r_lu_cnt, r_fl_cnt;
  logic [1:0]       w_fa, w_fb;
  logic             w_lu_a, w_lu_b, w_run, w_br, w_lu, w_bubble;
  slot_t            w_id;

  hz_fwd_sel u_sel_a (.i_used(bus.id_uses_rs1), .i_rs(bus.id_rs1), .i_ex(r_ex), .i_mem(r_mem),
                      .o_fwd(w_fa), .o_lu(w_lu_a));
  hz_fwd_sel u_sel_b (.i_used(bus.id_uses_rs2), .i_rs(bus.id_rs2), .i_ex(r_ex), .i_mem(r_mem),
                      .o_fwd(w_fb), .o_lu(w_lu_b));

  // LU_STALL leaves a bubble in EX, so it naturally behaves like RUN
  always_comb begin
    w_run    = r_state != ST_FLUSH;
    w_br     = w_run & bus.branch_taken_ex;
    w_lu     = w_run & !bus.branch_taken_ex & bus.id_valid & (w_lu_a | w_lu_b);
    w_bubble = !w_run | w_br | w_lu;
    w_id     = (w_bubble | !bus.id_valid) ? '0
             : slot_t'({1'b1, bus.id_rd, bus.id_wb_reg_file, bus.id_memtoreg});
  end

  assign bus.stall_if_id            = rst_n & (bus.mem_stall | w_lu);
  assign bus.bubble_id_ex           = rst_n & !bus.mem_stall & w_bubble;
  assign bus.flush_if_id            = rst_n & !bus.mem_stall & (!w_run | w_br);
  assign bus.operand_a_forward_cntl = r_fa;
  assign bus.operand_b_forward_cntl = r_fb;
  assign bus.lu_stall_cnt           = r_lu_cnt;
  assign bus.flush_cnt              = r_fl_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_fcnt   <= '0;
      r_ex     <= '0;
      r_mem    <= '0;
      r_fa     <= FWD_RF;
      r_fb     <= FWD_RF;
      r_lu_cnt <= '0;
      r_fl_cnt <= '0;
    end else if (!bus.mem_stall) begin
      r_mem <= r_ex;
      r_ex  <= w_id;
      r_fa  <= w_bubble ? FWD_RF : w_fa;
      r_fb  <= w_bubble ? FWD_RF : w_fb;
      if (w_br) begin
        r_fl_cnt <= r_fl_cnt + CNT_W'(r_fl_cnt != '1);
        r_state  <= (LP_FE != 3'd0) ? ST_FLUSH : ST_RUN;
        r_fcnt   <= LP_FE;
      end else if (w_lu) begin
        r_lu_cnt <= r_lu_cnt + CNT_W'(r_lu_cnt != '1);
        r_state  <= ST_LU_STALL;
      end else if (!w_run) begin
        r_fcnt  <= r_fcnt - 3'd1;
        r_state <= (r_fcnt == 3'd1) ? ST_RUN : ST_FLUSH;
      end else begin
        r_state <= ST_RUN;
      end
    end
  end
endmodule
